// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter
// Four-approach intersection phase scheduler (N=0, E=1, S=2, W=3).
// Round-robin green hand-off on vehicle demand, bounded by minimum and
// maximum green times, followed by yellow and all-red clearance. Emergency
// requests preempt through the same yellow/all-red clearance unless the
// emergency approach already holds green. Every output is a register
// updated on the same clock edge as the state.

module traffic_phase_arbiter #(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int CW        = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [3:0]    req,
    input  logic [3:0]    emrg_req,
    output logic [3:0]    green,
    output logic [3:0]    yellow,
    output logic          all_red,
    output logic [1:0]    cur_dir,
    output logic          preempt_active,
    output logic [CW-1:0] count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_ALLRED  = 3'd3,
        ST_PREEMPT = 3'd4
    } state_t;

    // A phase of T ticks ends on the tick cycle that sees count == T-1.
    localparam logic [CW-1:0] GMIN_LAST  = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST  = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_LAST   = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] RED_LAST   = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

    state_t        state_r;
    logic [1:0]    last_served_r;

    logic [1:0]    rr_pick_s;
    logic [1:0]    emrg_pick_s;
    logic [CW-1:0] count_inc_s;
    logic          other_req_s;
    logic          other_emrg_s;
    logic          gmin_hit_s;
    logic          gmax_hit_s;
    logic          yel_done_s;
    logic          red_done_s;

    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        dir_onehot = 4'b0001 << d;
    endfunction

    // Round-robin pick: nearest requesting approach after last_served, wrapping.
    always_comb begin
        logic [1:0] cand;
        rr_pick_s = 2'd0;
        cand      = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_served_r + 2'(i);
            if (req[cand]) begin
                rr_pick_s = cand;
            end else begin
                rr_pick_s = rr_pick_s;
            end
        end
    end

    // Emergency pick: fixed priority, lowest index wins.
    always_comb begin
        emrg_pick_s = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (emrg_req[i]) begin
                emrg_pick_s = 2'(i);
            end else begin
                emrg_pick_s = emrg_pick_s;
            end
        end
    end

    // Saturating tick counter increment and phase-limit detection.
    always_comb begin
        if (count == CNT_SAT) begin
            count_inc_s = count;
        end else begin
            count_inc_s = count + CW'(1);
        end
        other_req_s  = |(req & ~dir_onehot(cur_dir));
        other_emrg_s = |(emrg_req & ~dir_onehot(cur_dir));
        gmin_hit_s   = tick && (count >= GMIN_LAST);
        gmax_hit_s   = tick && (count >= GMAX_LAST);
        yel_done_s   = tick && (count >= YEL_LAST);
        red_done_s   = tick && (count >= RED_LAST);
    end

    // Phase state machine with registered lamp outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            green          <= 4'b0000;
            yellow         <= 4'b0000;
            all_red        <= 1'b1;
            cur_dir        <= 2'd0;
            last_served_r  <= 2'd3;
            preempt_active <= 1'b0;
            count          <= {CW{1'b0}};
        end else begin
            if (tick) begin
                count <= count_inc_s;
            end else begin
                count <= count;
            end
            case (state_r)
                ST_IDLE, ST_ALLRED: begin
                    if ((state_r == ST_IDLE) || red_done_s) begin
                        if (|emrg_req) begin
                            state_r        <= ST_PREEMPT;
                            cur_dir        <= emrg_pick_s;
                            green          <= dir_onehot(emrg_pick_s);
                            yellow         <= 4'b0000;
                            all_red        <= 1'b0;
                            preempt_active <= 1'b1;
                            count          <= {CW{1'b0}};
                        end else if (|req) begin
                            state_r        <= ST_GREEN;
                            cur_dir        <= rr_pick_s;
                            last_served_r  <= rr_pick_s;
                            green          <= dir_onehot(rr_pick_s);
                            yellow         <= 4'b0000;
                            all_red        <= 1'b0;
                            preempt_active <= 1'b0;
                            count          <= {CW{1'b0}};
                        end else if (state_r == ST_ALLRED) begin
                            state_r <= ST_IDLE;
                            count   <= {CW{1'b0}};
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_GREEN: begin
                    if (emrg_req[cur_dir]) begin
                        // Emergency approach already green: keep lamps, no clearance.
                        state_r        <= ST_PREEMPT;
                        preempt_active <= 1'b1;
                        count          <= {CW{1'b0}};
                    end else if (other_emrg_s ||
                                 (other_req_s && (gmax_hit_s ||
                                                  (gmin_hit_s && !req[cur_dir])))) begin
                        state_r <= ST_YELLOW;
                        green   <= 4'b0000;
                        yellow  <= dir_onehot(cur_dir);
                        count   <= {CW{1'b0}};
                    end else begin
                        state_r <= ST_GREEN;
                    end
                end
                ST_YELLOW: begin
                    if (yel_done_s) begin
                        state_r <= ST_ALLRED;
                        yellow  <= 4'b0000;
                        all_red <= 1'b1;
                        count   <= {CW{1'b0}};
                    end else begin
                        state_r <= ST_YELLOW;
                    end
                end
                ST_PREEMPT: begin
                    if (!emrg_req[cur_dir]) begin
                        state_r        <= ST_YELLOW;
                        green          <= 4'b0000;
                        yellow         <= dir_onehot(cur_dir);
                        preempt_active <= 1'b0;
                        count          <= {CW{1'b0}};
                    end else begin
                        state_r <= ST_PREEMPT;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe all-red idle.
                    state_r        <= ST_IDLE;
                    green          <= 4'b0000;
                    yellow         <= 4'b0000;
                    all_red        <= 1'b1;
                    preempt_active <= 1'b0;
                    count          <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed bench for traffic_phase_arbiter. Expected lamp vectors are pushed
// to a scoreboard queue before each stimulus step and popped and compared
// once the step has been applied. Ticks are spaced one idle cycle apart.

module tb_traffic_phase_arbiter;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] req;
    logic [3:0] emrg_req;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       all_red;
    logic [1:0] cur_dir;
    logic       preempt_active;
    logic [4:0] count;

    int checks   = 0;
    int failures = 0;

    string       tag_q[$];
    logic [11:0] val_q[$];

    traffic_phase_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .req            (req),
        .emrg_req       (emrg_req),
        .green          (green),
        .yellow         (yellow),
        .all_red        (all_red),
        .cur_dir        (cur_dir),
        .preempt_active (preempt_active),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Expected vector layout: {green, yellow, all_red, cur_dir, preempt_active}
    function automatic logic [3:0] oh(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return one << d;
    endfunction
    function automatic logic [11:0] e_grn(input int d);
        return {oh(d), 4'b0000, 1'b0, 2'(d), 1'b0};
    endfunction
    function automatic logic [11:0] e_yel(input int d);
        return {4'b0000, oh(d), 1'b0, 2'(d), 1'b0};
    endfunction
    function automatic logic [11:0] e_red(input int d);
        return {4'b0000, 4'b0000, 1'b1, 2'(d), 1'b0};
    endfunction
    function automatic logic [11:0] e_pre(input int d);
        return {oh(d), 4'b0000, 1'b0, 2'(d), 1'b1};
    endfunction

    task automatic push(input string tag, input logic [11:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic pop_check();
        string       t;
        logic [11:0] e;
        logic [11:0] obs;
        checks++;
        if (val_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            t   = tag_q.pop_front();
            e   = val_q.pop_front();
            obs = {green, yellow, all_red, cur_dir, preempt_active};
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", t, obs, e);
            end
        end
    endtask

    task automatic chk_count(input string tag, input logic [4:0] e);
        checks++;
        assert (count === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, count, e);
        end
    endtask

    task automatic step(input logic tk);
        tick = tk;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    task automatic run_ticks(input string tag, input int n, input logic [11:0] e);
        push(tag, e);
        ticks(n);
        pop_check();
    endtask

    task automatic run_step(input string tag, input logic tk, input logic [11:0] e);
        push(tag, e);
        step(tk);
        pop_check();
    endtask

    // Lamp invariant: never green and yellow together, each at most one-hot.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            assert ((green == 4'b0000 || yellow == 4'b0000) && $onehot0(green) &&
                    $onehot0(yellow) &&
                    (all_red == (green == 4'b0000 && yellow == 4'b0000))) else begin
                failures++;
                $error("FAIL lamp_invariant observed=g%b y%b r%b expected=exclusive",
                       green, yellow, all_red);
            end
        end
    end

    initial begin
        rst      = 1'b0;
        tick     = 1'b0;
        req      = 4'b0000;
        emrg_req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        push("reset_vals", e_red(0));
        pop_check();
        chk_count("reset_count", 5'd0);
        rst = 1'b1;

        // First demand from idle
        req = 4'b0001;
        run_step("idle_to_green_n", 1'b1, e_grn(0));
        chk_count("green_entry_count", 5'd0);

        // Max green with competing demand
        req = 4'b0011;
        run_ticks("max_hold_n", 29, e_grn(0));
        chk_count("max_hold_count", 5'd29);
        run_ticks("max_yellow_n", 1, e_yel(0));
        chk_count("yellow_entry_count", 5'd0);
        run_ticks("yellow_hold_n", 4, e_yel(0));
        run_ticks("allred_n_1", 1, e_red(0));
        run_ticks("allred_n_2", 1, e_red(0));
        run_ticks("rr_green_e", 1, e_grn(1));

        // Min green once own demand is gone
        req = 4'b0100;
        run_ticks("min_hold_e", 9, e_grn(1));
        run_ticks("min_yellow_e", 1, e_yel(1));
        run_ticks("allred_e", 5, e_red(1));
        run_ticks("green_s", 2, e_grn(2));

        // Emergency on the green approach: no clearance
        emrg_req = 4'b0100;
        run_step("preempt_same_s", 1'b0, e_pre(2));
        run_ticks("preempt_hold_s", 3, e_pre(2));
        emrg_req = 4'b0000;
        run_step("preempt_release_s", 1'b0, e_yel(2));
        req = 4'b0000;
        run_ticks("allred_s", 5, e_red(2));
        run_ticks("to_idle", 2, e_red(2));
        run_ticks("idle_rest", 2, e_red(2));

        // Demand drops at tick 4, hand-off at min green
        req = 4'b0101;
        run_step("rr_from_s_to_n", 1'b1, e_grn(0));
        ticks(4);
        req = 4'b0100;
        run_ticks("drop_hold_n", 5, e_grn(0));
        chk_count("drop_hold_count", 5'd9);
        run_ticks("drop_yellow_n", 1, e_yel(0));
        run_ticks("drop_allred_n", 5, e_red(0));
        run_ticks("drop_green_s", 2, e_grn(2));

        // Get green on East, then emergency West at count 3
        req = 4'b0010;
        run_ticks("s_hold", 9, e_grn(2));
        run_ticks("s_yellow", 1, e_yel(2));
        run_ticks("s_allred", 5, e_red(2));
        run_ticks("rr_green_e2", 2, e_grn(1));
        ticks(3);
        chk_count("e_count3", 5'd3);
        emrg_req = 4'b1000;
        run_step("emrg_yellow_e", 1'b0, e_yel(1));
        run_ticks("emrg_allred_e", 5, e_red(1));
        run_ticks("emrg_allred_hold", 1, e_red(1));
        run_ticks("preempt_w", 1, e_pre(3));
        emrg_req = 4'b1001;
        run_ticks("preempt_ignore_n", 2, e_pre(3));
        emrg_req = 4'b0000;
        run_step("preempt_exit_w", 1'b0, e_yel(3));

        // Async reset during yellow, no clock edge
        #2;
        rst = 1'b0;
        #1;
        push("async_reset", e_red(0));
        pop_check();
        chk_count("async_reset_count", 5'd0);
        req = 4'b1111;
        run_step("reset_hold", 1'b1, e_red(0));
        rst = 1'b1;

        // Full round-robin with every approach demanding
        run_step("rr_start_n", 1'b1, e_grn(0));
        for (int d = 0; d < 4; d++) begin
            run_ticks($sformatf("rr_hold_%0d", d), 29, e_grn(d));
            run_ticks($sformatf("rr_yellow_%0d", d), 1, e_yel(d));
            run_ticks($sformatf("rr_allred_%0d", d), 5, e_red(d));
            run_ticks($sformatf("rr_next_%0d", d), 2, e_grn((d + 1) % 4));
        end

        // Emergency beats demand in idle, lowest index wins
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req      = 4'b0001;
        emrg_req = 4'b0110;
        run_step("idle_emrg_prio", 1'b0, e_pre(1));
        emrg_req = 4'b0000;

        // Green rests with no competing demand, count saturates
        rst = 1'b0;
        #1;
        rst = 1'b1;
        run_step("rest_green_n", 1'b1, e_grn(0));
        run_ticks("rest_hold_n", 35, e_grn(0));
        chk_count("rest_saturate", 5'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_arbiter.md
Name: traffic_phase_arbiter

Overview:
- Scheduler for a four-approach intersection (North=0, East=1, South=2, West=3).
- Decides which approach owns green, using round-robin over vehicle-sensor demand.
- Enforces minimum green, maximum green, yellow and all-red clearance times, counted in external 1-second ticks.
- Grants emergency-vehicle preemption through a safe yellow/all-red clearance. Its one-hot outputs drive the per-direction lamp decode.

Parameters:
- GREEN_MIN, 10, minimum green ticks before a demand-driven hand-off.
- GREEN_MAX, 30, maximum green ticks while another approach is waiting.
- YELLOW_T, 5, yellow ticks.
- ALLRED_T, 2, all-red clearance ticks.
- CW, 5, counter width; must hold GREEN_MAX.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- tick  in  1  one-cycle pulse per second; all timing advances only on tick.
- req  in  4  vehicle demand per approach, level-sensitive.
- emrg_req  in  4  emergency preemption request per approach, level-sensitive.
- green  out  4  one-hot green approach, or 0.
- yellow  out  4  one-hot yellow approach, or 0.
- all_red  out  1  high when green==0 and yellow==0.
- cur_dir  out  2  approach currently or last owning the phase.
- preempt_active  out  1  high in PREEMPT state.
- count  out  CW  tick counter within the current state.

Behaviour:
- Registered Moore outputs; all state and outputs update on the same clk edge.
- Reset values: state=IDLE, green=0, yellow=0, all_red=1, cur_dir=0, last_served=3 (so North is searched first), preempt_active=0, count=0.
- count clears to 0 on every state entry. It increments on each tick cycle and saturates at 2^CW-1.
- "Count reaches T" means a tick cycle with count==T-1 (or more), so a phase lasts exactly T ticks.
- RR pick: first set req bit searching from (last_served+1) mod 4 upward, wrapping. last_served and cur_dir load on GREEN entry.
- EMRG pick: lowest-index set emrg_req bit (fixed priority N>E>S>W).
- IDLE: all red.
  - Any emrg_req -> PREEMPT on EMRG pick, next edge, no tick needed.
  - Else any req -> GREEN on RR pick.
  - emrg_req takes precedence over req in the same cycle.
- GREEN (green[cur_dir]=1):
  - emrg_req[cur_dir]=1 -> PREEMPT, same direction, count cleared, no yellow.
  - Else any other emrg_req bit -> YELLOW immediately, ignoring GREEN_MIN.
  - Else, if another approach has req AND (count reaches GREEN_MAX, OR count>=GREEN_MIN and req[cur_dir]=0) -> YELLOW.
  - With no other demand, green rests indefinitely and count saturates.
- YELLOW (yellow[cur_dir]=1): after YELLOW_T ticks -> ALLRED. No request can shorten or abort yellow.
- ALLRED: after ALLRED_T ticks:
  - Any emrg_req -> PREEMPT on EMRG pick.
  - Else any req -> GREEN on RR pick.
  - Else -> IDLE.
  - Requests are sampled on the exit cycle; pulses that drop earlier are lost.
- PREEMPT:
  - green on target; cur_dir=target; preempt_active=1; last_served unchanged.
  - Held while emrg_req[target]=1. Other emrg bits are ignored.
  - Target drops -> YELLOW on target, then normal flow.
- Reset asserted mid-phase forces the reset values immediately (async). Operation restarts from IDLE after release.
- Invariant: green and yellow are never both nonzero; each is at most one-hot.

Test Plan:
- Reset, req=0001, 1 tick -> green=0001 on next edge, cur_dir=0, all_red=0.
- Green on N, req=0011 held, ticks continuous:
  - yellow=0001 after 30 ticks, then all_red for 2 ticks.
  - Then green=0010, after 5 yellow ticks.
- Green on N with req=0100, req[0] drops at tick 4 -> stays green until count reaches 10, then yellow=0001; next green=0100.
- Green on E at count=3, emrg_req=1000:
  - yellow=0010 next edge.
  - After 5 yellow + 2 all-red ticks: green=1000, preempt_active=1.
  - emrg_req=0000 -> yellow=1000.
- Green on S, emrg_req=0100 -> PREEMPT without yellow; preempt_active=1, green=0100 held.
- IDLE, req=1111:
  - Served order N,E,S,W,N.
  - Each handoff passes yellow and all-red.
- rst=0 asserted during YELLOW -> outputs at reset values immediately with no clock.
